// File: rtl/ken_anim_sequencer_if.sv
// Control and pose bundle between the game logic (master) and the Ken animation sequencer (slave).
interface ken_anim_sequencer_if;
    logic       frame_tick;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       punch;
    logic       kick;
    logic       special;
    logic       ko;
    logic [5:0] ken;
    logic       busy;
    logic       hit_active;
    logic       special_launch;
    logic [5:0] y_offset;

    modport master (
        output frame_tick, left, right, up, down, punch, kick, special, ko,
        input  ken, busy, hit_active, special_launch, y_offset
    );

    modport slave (
        input  frame_tick, left, right, up, down, punch, kick, special, ko,
        output ken, busy, hit_active, special_launch, y_offset
    );
endinterface

// File: rtl/ken_anim_sequencer.sv
// Ken animation sequencer: frame-stepped pose FSM feeding the sprite colour mapper.
// Defining KEN_JUMP_ARC_EN adds the registered jump-height table on y_offset.
module ken_anim_sequencer #(
    parameter int FRAMES_PER_STEP = 6,
    parameter int CNT_W           = 4
) (
    input logic                 Clk,
    input logic                 Reset,
    ken_anim_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, WALK_F, WALK_B, CROUCH, PUNCH, KICK, CROUCH_PUNCH, JUMP, SPECIAL, KO
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    state_e           state_q, state_d, req;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       ken_q, ken_d;
    logic             busy_q, hit_q, launch_q;
    logic             step;

    function automatic logic [5:0] first_code(input state_e s);
        case (s)
            WALK_F:       return 6'd4;
            WALK_B:       return 6'd12;
            CROUCH:       return 6'd20;
            PUNCH:        return 6'd8;
            KICK:         return 6'd16;
            CROUCH_PUNCH: return 6'd21;
            JUMP:         return 6'd24;
            SPECIAL:      return 6'd29;
            KO:           return 6'd33;
            default:      return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] last_code(input state_e s);
        case (s)
            PUNCH:        return 6'd11;
            KICK:         return 6'd19;
            CROUCH_PUNCH: return 6'd23;
            JUMP:         return 6'd28;
            SPECIAL:      return 6'd32;
            default:      return 6'd35;
        endcase
    endfunction

    function automatic logic is_busy(input state_e s);
        return s inside {PUNCH, KICK, CROUCH_PUNCH, JUMP, SPECIAL, KO};
    endfunction

    function automatic logic hit_code(input logic [5:0] c);
        return c inside {6'd10, 6'd18, 6'd22, 6'd31, 6'd32};
    endfunction

    always_comb begin
        req = IDLE;
        if (bus.special)    req = SPECIAL;
        else if (bus.punch) req = bus.down ? CROUCH_PUNCH : PUNCH;
        else if (bus.kick)  req = KICK;
        else if (bus.up)    req = JUMP;
        else if (bus.down)  req = CROUCH;
        else if (bus.right) req = WALK_F;
        else if (bus.left)  req = WALK_B;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ken_d   = ken_q;
        step    = 1'b0;
        if (bus.frame_tick) begin
            if (bus.ko && state_q != KO)
                state_d = KO;
            else if (!is_busy(state_q) && req != state_q)
                state_d = req;
            else
                step = 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
            ken_d = first_code(state_d);
        end else if (step) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                // Looping ranges are 4-aligned, so only the low two bits wrap
                case (state_q)
                    IDLE, WALK_F, WALK_B: ken_d = {ken_q[5:2], ken_q[1:0] + 2'd1};
                    CROUCH:               ken_d = ken_q;
                    KO:                   ken_d = (ken_q == 6'd35) ? ken_q : ken_q + 6'd1;
                    default: begin
                        if (ken_q == last_code(state_q)) begin
                            if (state_q == CROUCH_PUNCH && bus.down) begin
                                state_d = CROUCH;
                                ken_d   = 6'd20;
                            end else begin
                                state_d = IDLE;
                                ken_d   = 6'd0;
                            end
                        end else begin
                            ken_d = ken_q + 6'd1;
                        end
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ken_q    <= '0;
            busy_q   <= 1'b0;
            hit_q    <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ken_q    <= ken_d;
            busy_q   <= is_busy(state_d);
            hit_q    <= hit_code(ken_d);
            launch_q <= (ken_d == 6'd32) && (ken_q != 6'd32);
        end
    end

    assign bus.ken            = ken_q;
    assign bus.busy           = busy_q;
    assign bus.hit_active     = hit_q;
    assign bus.special_launch = launch_q;

`ifdef KEN_JUMP_ARC_EN
    logic [5:0] yoff_q;

    function automatic logic [5:0] jump_arc(input logic [5:0] c);
        case (c)
            6'd25, 6'd28: return 6'd24;
            6'd26, 6'd27: return 6'd40;
            default:      return 6'd0;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) yoff_q <= '0;
        else       yoff_q <= jump_arc(ken_d);
    end

    assign bus.y_offset = yoff_q;
`else
    assign bus.y_offset = 6'd0;
`endif
endmodule
